// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_frame
//  Purpose  : UART transmit controller owning the complete frame: start bit,
//             LSB-first data, optional even/odd parity and one or two stop
//             bits. Every bit is paced by an external one-cycle baud strobe.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_W      data bits per frame (5..9)
//    STOP_BITS   stop bits per frame (1 or 2)
//  Ports
//    CLK         system clock, rising edge
//    RST         asynchronous reset, active low
//    BAUD_TICK   one-cycle strobe; one transmitted bit per tick period
//    P_DATA      parallel data word
//    Data_Valid  host offers P_DATA
//    PAR_EN      include a parity bit
//    PAR_TYP     parity type: 0 = even, 1 = odd
//    Data_Ready  a word can be accepted this cycle
//    TX_OUT      serial line, idles high
//    busy        a frame is pending or being transmitted
//    frame_done  one-cycle pulse after the last stop bit
//  Build option
//    UART_TX_HOLD_BUF_EN  adds a one-entry holding buffer so frames can be
//                         chained back-to-back without an idle bit.
// ============================================================================
module uart_tx_frame #(
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              BAUD_TICK,
    input  logic [DATA_W-1:0] P_DATA,
    input  logic              Data_Valid,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    output logic              Data_Ready,
    output logic              TX_OUT,
    output logic              busy,
    output logic              frame_done
);

    localparam int               CNT_W       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] C_LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic             C_LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               stop_cnt_q, stop_cnt_d;
    logic               par_en_q, par_en_d;
    logic               par_bit_q, par_bit_d;
    logic               frame_done_q, frame_done_d;

    logic               w_accept;
    logic               w_pending;
    logic               w_busy;
    logic               w_launch;
    logic               w_new_par;
    logic               w_tx;

`ifdef UART_TX_HOLD_BUF_EN
    logic [DATA_W-1:0]  buf_q, buf_d;
    logic               buf_par_en_q, buf_par_en_d;
    logic               buf_par_q, buf_par_d;
    logic               buf_full_q, buf_full_d;

    assign w_pending  = buf_full_q;
    assign Data_Ready = ~buf_full_q;
`else
    logic               pend_q, pend_d;

    assign w_pending  = pend_q;
    assign Data_Ready = ~w_busy;
`endif

    assign w_busy    = (state_q != S_IDLE) || w_pending;
    assign w_accept  = Data_Valid && Data_Ready;
    // Parity is fixed at acceptance so later input changes cannot alter it.
    assign w_new_par = (^P_DATA) ^ PAR_TYP;

    // ------------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        par_en_d     = par_en_q;
        par_bit_d    = par_bit_q;
        frame_done_d = 1'b0;
        w_launch     = 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
        buf_d        = buf_q;
        buf_par_en_d = buf_par_en_q;
        buf_par_d    = buf_par_q;
        buf_full_d   = buf_full_q;
`else
        pend_d       = pend_q;
`endif

        if (BAUD_TICK) begin
            case (state_q)
                S_IDLE: begin
                    if (w_pending) begin
                        state_d  = S_START;
                        w_launch = 1'b1;
                    end
                end
                S_START: begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
                S_DATA: begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == C_LAST_BIT) begin
                        state_d    = par_en_q ? S_PARITY : S_STOP;
                        stop_cnt_d = 1'b0;
                    end
                end
                S_PARITY: begin
                    state_d    = S_STOP;
                    stop_cnt_d = 1'b0;
                end
                S_STOP: begin
                    if (stop_cnt_q == C_LAST_STOP) begin
                        frame_done_d = 1'b1;
                        // A word accepted on this very edge also chains; it
                        // can only happen when the holding buffer exists.
                        if (w_pending || w_accept) begin
                            state_d  = S_START;
                            w_launch = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

`ifdef UART_TX_HOLD_BUF_EN
        if (w_launch) begin
            if (buf_full_q) begin
                shift_d    = buf_q;
                par_en_d   = buf_par_en_q;
                par_bit_d  = buf_par_q;
                buf_full_d = 1'b0;
            end else begin
                // Buffer empty: the word arriving on the final stop tick goes
                // straight into the shift register.
                shift_d   = P_DATA;
                par_en_d  = PAR_EN;
                par_bit_d = w_new_par;
            end
        end
        if (w_accept && !w_launch) begin
            buf_d        = P_DATA;
            buf_par_en_d = PAR_EN;
            buf_par_d    = w_new_par;
            buf_full_d   = 1'b1;
        end
`else
        // Without a buffer the word waits in the shift register while idle.
        if (w_launch) begin
            pend_d = 1'b0;
        end
        if (w_accept) begin
            shift_d   = P_DATA;
            par_en_d  = PAR_EN;
            par_bit_d = w_new_par;
            pend_d    = 1'b1;
        end
`endif
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            par_en_q     <= 1'b0;
            par_bit_q    <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
            buf_q        <= '0;
            buf_par_en_q <= 1'b0;
            buf_par_q    <= 1'b0;
            buf_full_q   <= 1'b0;
`else
            pend_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            par_en_q     <= par_en_d;
            par_bit_q    <= par_bit_d;
            frame_done_q <= frame_done_d;
`ifdef UART_TX_HOLD_BUF_EN
            buf_q        <= buf_d;
            buf_par_en_q <= buf_par_en_d;
            buf_par_q    <= buf_par_d;
            buf_full_q   <= buf_full_d;
`else
            pend_q       <= pend_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Line decode: depends on registered state only, so reset forces the
    // line high immediately.
    // ------------------------------------------------------------------------
    always_comb begin
        w_tx = 1'b1;
        case (state_q)
            S_START:  w_tx = 1'b0;
            S_DATA:   w_tx = shift_q[0];
            S_PARITY: w_tx = par_bit_q;
            default:  w_tx = 1'b1;
        endcase
    end

    assign TX_OUT     = w_tx;
    assign busy       = w_busy;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_frame
//  Purpose  : Self-checking bench for uart_tx_frame. Two instances share the
//             stimulus: A (DATA_W=8, STOP_BITS=1) and B (DATA_W=5,
//             STOP_BITS=2). Expected line/busy/done/ready values come from a
//             bit-list model of the frame indexed by the number of baud ticks
//             seen since acceptance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       baud_tick;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;

    logic ready_a, tx_a, busy_a, done_a;
    logic ready_b, tx_b, busy_b, done_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_W(8), .STOP_BITS(1)) dut_a (
        .CLK(clk), .RST(rst_n), .BAUD_TICK(baud_tick), .P_DATA(p_data),
        .Data_Valid(data_valid), .PAR_EN(par_en), .PAR_TYP(par_typ),
        .Data_Ready(ready_a), .TX_OUT(tx_a), .busy(busy_a), .frame_done(done_a)
    );

    uart_tx_frame #(.DATA_W(5), .STOP_BITS(2)) dut_b (
        .CLK(clk), .RST(rst_n), .BAUD_TICK(baud_tick), .P_DATA(p_data[4:0]),
        .Data_Valid(data_valid), .PAR_EN(par_en), .PAR_TYP(par_typ),
        .Data_Ready(ready_b), .TX_OUT(tx_b), .busy(busy_b), .frame_done(done_b)
    );

    // Frame as a list of line levels: start, data LSB first, parity, stops.
    function automatic void build_frame(input logic [8:0] d, input int w, input int s,
                                        input bit pe, input bit pt,
                                        output logic [31:0] bits, output int len);
        int ones;
        ones = 0;
        bits = '1;
        len  = 0;
        bits[len] = 1'b0;
        len++;
        for (int i = 0; i < w; i++) begin
            bits[len] = d[i];
            ones += int'(d[i]);
            len++;
        end
        if (pe) begin
            bits[len] = ((ones % 2) == 1) ^ pt;
            len++;
        end
        len += s;
    endfunction

    // Expected {tx, busy, frame_done, ready} after k ticks past acceptance.
    function automatic logic [3:0] model_out(input logic [31:0] bits, input int len,
                                             input int k, input bit last_tick);
        logic tx, bsy, fd, rdy;
        tx  = (k == 0 || k > len) ? 1'b1 : bits[k-1];
        bsy = (k <= len);
        fd  = last_tick && (k == len + 1);
`ifdef UART_TX_HOLD_BUF_EN
        rdy = (k >= 1);
`else
        rdy = ~bsy;
`endif
        return {tx, bsy, fd, rdy};
    endfunction

    // Sends one word to both instances and checks every cycle of the frame.
    task automatic run_frame(input logic [7:0] d, input bit pe, input bit pt,
                             input int period, input bit tick_at_accept,
                             input int abort_k, input bit offer_busy, input string name);
        logic [31:0] ba, bb;
        int          la, lb, lmax, k, c, phase;
        bit          last_tick;
        logic [3:0]  exp_v, obs_v;
        build_frame(9'(d), 8, 1, pe, pt, ba, la);
        build_frame(9'(d[4:0]), 5, 2, pe, pt, bb, lb);
        lmax = (la > lb) ? la : lb;
        @(negedge clk);
        p_data = d; par_en = pe; par_typ = pt; data_valid = 1'b1;
        baud_tick = tick_at_accept;
        @(posedge clk); #1;
        // Scramble inputs: the latched frame must not follow them.
        data_valid = 1'b0;
        p_data  = 8'($urandom);
        par_en  = 1'($urandom);
        par_typ = 1'($urandom);
        baud_tick = 1'b0;
        k = 0; c = 0; last_tick = 1'b0;
        phase = int'($urandom_range(0, period - 1));
        forever begin
            @(negedge clk);
            exp_v = model_out(ba, la, k, last_tick);
            obs_v = {tx_a, busy_a, done_a, ready_a};
            n_checks++;
            if (obs_v !== exp_v)
                $display("FAIL %s dut_a k=%0d: tx/busy/done/ready got %b expected %b", name, k, obs_v, exp_v);
            else
                n_pass++;
            exp_v = model_out(bb, lb, k, last_tick);
            obs_v = {tx_b, busy_b, done_b, ready_b};
            n_checks++;
            if (obs_v !== exp_v)
                $display("FAIL %s dut_b k=%0d: tx/busy/done/ready got %b expected %b", name, k, obs_v, exp_v);
            else
                n_pass++;
            if (k > lmax + 1 || (abort_k != 0 && k == abort_k)) break;
            c++;
            baud_tick  = ((c + phase) % period) == 0;
            data_valid = offer_busy && (c <= 3);
            if (data_valid) p_data = 8'h80;
            @(posedge clk); #1;
            last_tick = baud_tick;
            if (baud_tick) k++;
        end
        baud_tick  = 1'b0;
        data_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        data_valid = 1'b0;
        baud_tick  = 1'b1;
        while ((busy_a || busy_b) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        baud_tick = 1'b0;
        n_checks++;
        if (busy_a || busy_b)
            $display("FAIL %s drain: busy_a=%b busy_b=%b expected 0 0", name, busy_a, busy_b);
        else
            n_pass++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; baud_tick = 1'b0; data_valid = 1'b0;
        p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({tx_a, busy_a, done_a, ready_a, tx_b, busy_b, done_b, ready_b} !== 8'b1001_1001)
                $display("FAIL reset_hold: a=%b b=%b expected 1001 1001",
                         {tx_a, busy_a, done_a, ready_a}, {tx_b, busy_b, done_b, ready_b});
            else
                n_pass++;
            // Activity during reset must leave no trace.
            baud_tick = 1'b1; data_valid = (i < 3); p_data = 8'h5A;
        end
        @(negedge clk);
        data_valid = 1'b0; baud_tick = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({tx_a, busy_a, done_a, ready_a, tx_b, busy_b, done_b, ready_b} !== 8'b1001_1001)
            $display("FAIL reset_release: a=%b b=%b expected 1001 1001",
                     {tx_a, busy_a, done_a, ready_a}, {tx_b, busy_b, done_b, ready_b});
        else
            n_pass++;
    endtask

    task automatic test_basic;
        run_frame(8'hA5, 1'b0, 1'b0, 4, 1'b0, 0, 1'b0, "basic_a5");
    endtask

    task automatic test_parity;
        run_frame(8'h07, 1'b1, 1'b0, 3, 1'b0, 0, 1'b0, "parity_even");
        run_frame(8'h07, 1'b1, 1'b1, 3, 1'b0, 0, 1'b0, "parity_odd");
    endtask

    task automatic test_w5_stop2;
        run_frame(8'h1F, 1'b0, 1'b0, 2, 1'b0, 0, 1'b0, "w5_stop2_1f");
    endtask

    task automatic test_tick_on_accept;
        run_frame(8'hC3, 1'b0, 1'b0, 3, 1'b1, 0, 1'b0, "tick_on_accept");
        run_frame(8'h3C, 1'b1, 1'b1, 1, 1'b1, 0, 1'b0, "tick_on_accept_cont");
    endtask

    task automatic test_continuous_tick;
        run_frame(8'h96, 1'b1, 1'b0, 1, 1'b0, 0, 1'b0, "continuous_tick");
    endtask

    task automatic test_idle_tick;
        baud_tick = 1'b1; data_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({tx_a, busy_a, done_a, ready_a, tx_b, busy_b, done_b, ready_b} !== 8'b1001_1001)
                $display("FAIL idle_tick: a=%b b=%b expected 1001 1001",
                         {tx_a, busy_a, done_a, ready_a}, {tx_b, busy_b, done_b, ready_b});
            else
                n_pass++;
        end
        baud_tick = 1'b0;
    endtask

    task automatic test_mid_frame_reset;
        // Stop after 5 ticks: both instances are sending data bit 3 (a 0).
        run_frame(8'h35, 1'b0, 1'b0, 2, 1'b0, 5, 1'b0, "mid_reset_pre");
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tx_a, busy_a, done_a, ready_a, tx_b, busy_b, done_b, ready_b} !== 8'b1001_1001)
            $display("FAIL mid_reset_async: a=%b b=%b expected 1001 1001",
                     {tx_a, busy_a, done_a, ready_a}, {tx_b, busy_b, done_b, ready_b});
        else
            n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        baud_tick = 1'b1;
        @(negedge clk);
        baud_tick = 1'b0;
        n_checks++;
        if ({tx_a, busy_a, done_a, ready_a, tx_b, busy_b, done_b, ready_b} !== 8'b1001_1001)
            $display("FAIL mid_reset_first_tick: a=%b b=%b expected 1001 1001",
                     {tx_a, busy_a, done_a, ready_a}, {tx_b, busy_b, done_b, ready_b});
        else
            n_pass++;
        run_frame(8'h6B, 1'b1, 1'b0, 2, 1'b0, 0, 1'b0, "mid_reset_post");
    endtask

`ifdef UART_TX_HOLD_BUF_EN
    // Two frames on instance A: 8'h01 then 8'h80, expected as one continuous
    // bit list. late=1 offers the second word on the final stop tick edge.
    task automatic hold_chain(input bit late, input string name);
        logic [31:0] b1, b2, all_bits;
        int          l1, l2, total, k, c;
        bit          last_tick, offer;
        logic [2:0]  exp_v, obs_v;
        logic [3:0]  m;
        build_frame(9'h001, 8, 1, 1'b0, 1'b0, b1, l1);
        build_frame(9'h080, 8, 1, 1'b0, 1'b0, b2, l2);
        all_bits = (b1 & ((32'd1 << l1) - 32'd1)) | (b2 << l1);
        total    = l1 + l2;
        @(negedge clk);
        p_data = 8'h01; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1; baud_tick = 1'b0;
        @(posedge clk); #1;
        data_valid = 1'b0;
        k = 0; c = 0; last_tick = 1'b0; offer = ~late;
        forever begin
            @(negedge clk);
            m     = model_out(all_bits, total, k, last_tick);
            exp_v = {m[3], m[2], m[1] | (last_tick && k == l1 + 1)};
            obs_v = {tx_a, busy_a, done_a};
            n_checks++;
            if (obs_v !== exp_v)
                $display("FAIL %s k=%0d: tx/busy/done got %b expected %b", name, k, obs_v, exp_v);
            else
                n_pass++;
            if (k > total + 1) break;
            c++;
            baud_tick  = (c % 2) == 0;
            data_valid = 1'b0;
            if (offer && ready_a) begin
                data_valid = 1'b1; p_data = 8'h80; offer = 1'b0;
            end
            if (late && baud_tick && k == l1) begin
                data_valid = 1'b1; p_data = 8'h80;
            end
            @(posedge clk); #1;
            last_tick = baud_tick;
            if (baud_tick) k++;
        end
        baud_tick = 1'b0; data_valid = 1'b0;
    endtask
`endif

    task automatic test_back_to_back;
`ifdef UART_TX_HOLD_BUF_EN
        hold_chain(1'b0, "b2b_buffered");
        wait_idle("b2b_buffered");
        hold_chain(1'b1, "b2b_same_edge");
        wait_idle("b2b_same_edge");
`else
        // 8'h80 offered while busy must be ignored: the model expects a
        // single frame with the line idle afterwards.
        run_frame(8'h01, 1'b0, 1'b0, 2, 1'b0, 0, 1'b1, "b2b_reject");
`endif
    endtask

    task automatic test_random;
        for (int i = 0; i < 10; i++) begin
            run_frame(8'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(1, 5)), 1'($urandom), 0, 1'b0, "random");
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_parity;
        test_w5_stop2;
        test_tick_on_accept;
        test_continuous_tick;
        test_idle_tick;
        test_mid_frame_reset;
        test_back_to_back;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
